// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the hazard scoreboard.
// Imported by the scoreboard top and its busy-bit sub-module.
package hazard_pkg;

   localparam int NREG_DEF      = 32;
   localparam int MAX_OUT_DEF   = 4;
   localparam int FLUSH_CYC_DEF = 2;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } hz_state_e;

endpackage

// File: rtl/scoreboard_bits.sv
// Busy bit per architectural register plus outstanding long-op count.
// Register 0 is masked so it can never read as busy.
module scoreboard_bits
   import hazard_pkg::*;
#(
   parameter int NREG    = NREG_DEF,
   parameter int AW      = $clog2(NREG),
   parameter int MAX_OUT = MAX_OUT_DEF,
   parameter int PW      = $clog2(MAX_OUT + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue,
   input  logic [AW-1:0]   issue_rd,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   output logic [NREG-1:0] busy_vec,
   output logic [PW-1:0]   pend_cnt,
   output logic            completing,
   output logic            bad_wb
);

   localparam logic [NREG-1:0] X0_MASK = NREG'(1);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [PW-1:0]   pend_q;

   assign completing = wb_valid && busy_q[wb_rd];
   assign bad_wb     = wb_valid && !busy_q[wb_rd];
   assign busy_vec   = busy_q;
   assign pend_cnt   = pend_q;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue)
         set_mask[issue_rd] = 1'b1;
      if (completing)
         clr_mask[wb_rd] = 1'b1;
   end

   // Clear before set: a same-register issue/complete keeps the bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         pend_q <= '0;
      end else begin
         busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~X0_MASK;
         unique case ({issue, completing})
            2'b10:   pend_q <= pend_q + PW'(1);
            2'b01:   pend_q <= pend_q - PW'(1);
            default: pend_q <= pend_q;
         endcase
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detection: RAW/WAW on long ops, load-use, capacity,
// and branch flush sequencing, driving the front-end stall controls.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREG      = NREG_DEF,
   parameter int AW        = $clog2(NREG),
   parameter int MAX_OUT   = MAX_OUT_DEF,
   parameter int FLUSH_CYC = FLUSH_CYC_DEF,
   parameter int BYPASS_WB = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         id_valid,
   input  logic [AW-1:0]                id_rs1,
   input  logic [AW-1:0]                id_rs2,
   input  logic [AW-1:0]                id_rd,
   input  logic                         id_uses_rs1,
   input  logic                         id_uses_rs2,
   input  logic                         id_writes_rd,
   input  logic                         id_long,
   input  logic                         ex_valid,
   input  logic                         ex_mem_read,
   input  logic [AW-1:0]                ex_rd,
   input  logic                         ex_branch_taken,
   input  logic                         wb_long_valid,
   input  logic [AW-1:0]                wb_long_rd,
   output logic                         pc_write,
   output logic                         if_id_write,
   output logic                         if_id_flush,
   output logic                         id_ex_bubble,
   output logic [NREG-1:0]              busy_vec,
   output logic [$clog2(MAX_OUT+1)-1:0] pend_cnt,
   output logic                         sb_err,
   output logic [15:0]                  stall_cnt
);

   localparam int PW = $clog2(MAX_OUT + 1);
   localparam int CW = $clog2(FLUSH_CYC + 1);
   localparam logic [CW-1:0] RELOAD = CW'(FLUSH_CYC - 1);
   localparam logic BYP = (BYPASS_WB != 0);

   hz_state_e     state_q, state_d;
   logic [CW-1:0] fcnt_q, fcnt_d;

   logic completing, bad_wb;
   logic byp_rs1, byp_rs2, byp_rd;
   logic haz_rs1, haz_rs2, haz_waw, haz_lu, haz_cap;
   logic lu_rs1, lu_rs2;
   logic stall, flush_act, issue;

   scoreboard_bits #(
      .NREG    (NREG),
      .AW      (AW),
      .MAX_OUT (MAX_OUT),
      .PW      (PW)
   ) u_bits (
      .clk        (clk),
      .rst        (rst),
      .issue      (issue),
      .issue_rd   (id_rd),
      .wb_valid   (wb_long_valid),
      .wb_rd      (wb_long_rd),
      .busy_vec   (busy_vec),
      .pend_cnt   (pend_cnt),
      .completing (completing),
      .bad_wb     (bad_wb)
   );

   assign byp_rs1 = BYP && wb_long_valid && (wb_long_rd == id_rs1);
   assign byp_rs2 = BYP && wb_long_valid && (wb_long_rd == id_rs2);
   assign byp_rd  = BYP && wb_long_valid && (wb_long_rd == id_rd);

   assign haz_rs1 = id_uses_rs1 && (id_rs1 != '0)
                 && busy_vec[id_rs1] && !byp_rs1;
   assign haz_rs2 = id_uses_rs2 && (id_rs2 != '0)
                 && busy_vec[id_rs2] && !byp_rs2;
   assign haz_waw = id_writes_rd && (id_rd != '0)
                 && busy_vec[id_rd] && !byp_rd;

   assign lu_rs1 = id_uses_rs1 && (id_rs1 != '0) && (id_rs1 == ex_rd);
   assign lu_rs2 = id_uses_rs2 && (id_rs2 != '0) && (id_rs2 == ex_rd);
   assign haz_lu = ex_valid && ex_mem_read && (ex_rd != '0)
                && (lu_rs1 || lu_rs2);

   // A completion this cycle frees a slot for the incoming long op.
   assign haz_cap = id_long && (pend_cnt == PW'(MAX_OUT)) && !completing;

   assign stall = id_valid && (state_q == RUN)
               && (haz_rs1 || haz_rs2 || haz_waw || haz_lu || haz_cap);

   assign flush_act = (state_q == FLUSH)
                   || ((state_q == RUN) && ex_branch_taken);

   assign issue = id_valid && id_long && id_writes_rd && (id_rd != '0)
               && !stall && !flush_act;

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      unique case (1'b1)
         flush_act: begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end
         (stall && !flush_act): begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         RUN: begin
            if (ex_branch_taken && (FLUSH_CYC > 1)) begin
               state_d = FLUSH;
               fcnt_d  = RELOAD;
            end
         end
         FLUSH: begin
            if (ex_branch_taken) begin
               fcnt_d = RELOAD;
            end else if (fcnt_q == CW'(1)) begin
               state_d = RUN;
               fcnt_d  = '0;
            end else begin
               fcnt_d = fcnt_q - CW'(1);
            end
         end
         default: begin
            state_d = RUN;
            fcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         fcnt_q    <= '0;
         sb_err    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         if (bad_wb)
            sb_err <= 1'b1;
         if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule
